fb_scanout: RTL and testbench

Parametrised frame-buffer scan-out engine and successor to the single-buffer fixed-800x480 frame buffer reader.
- Burst-reads 32-bit pixels from HPS SDRAM over the Avalon-MM f2h_sdram0 port into a pixel FIFO.
- Drives RGB to the LCD path in step with the LCD_control timing strobes.
- Adds runtime double buffering (page flip at frame boundary), configurable resolution and burst size, variable last-burst length, and underflow accounting.

---
 rtl/fb_scanout.sv | 274 +++++++++++++++++++++++++++
 tb/tb_fb_scanout.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
// fb_scanout - frame-buffer scan-out engine.
//
// Burst-reads 64-bit words (two 32-bit pixels each) from SDRAM over an
// Avalon-MM read master into a pixel FIFO. On each active LCD tick it pops
// pixels out to RGB. Supports a double-buffer page flip at the frame
// boundary, a variable-length last burst, and saturating underflow
// accounting.
//
// Ports:
//   clock, reset_n          system clock, asynchronous active-low reset
//   avm_*                   Avalon-MM read master (word addresses, bursts)
//   base_address0/1         byte base addresses of the two frame buffers
//   swap_request/swap_done  page-flip request pulse / flip-applied pulse
//   active_buffer           buffer currently being scanned
//   lcd_tick/next_frame/
//   lcd_data_enable         LCD timing strobes
//   lcd_red/green/blue      pixel colour, one lcd_tick behind data_enable
//   underflow_count         saturating count of pixels shown while starved
//
// Optional: define FB_TEST_PATTERN_EN to add a test_pattern input that
// replaces the FIFO colours with eight vertical colour bars.
module fb_scanout #(
  parameter int H_ACTIVE   = 800,
  parameter int V_ACTIVE   = 480,
  parameter int BURST_LEN  = 32,
  parameter int FIFO_DEPTH = 256,
  parameter int ADDR_WIDTH = 29
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic [ADDR_WIDTH-1:0] avm_address,
  output logic [7:0]            avm_burstcount,
  output logic                  avm_read,
  input  logic                  avm_waitrequest,
  input  logic [63:0]           avm_readdata,
  input  logic                  avm_readdatavalid,
  input  logic [31:0]           base_address0,
  input  logic [31:0]           base_address1,
  input  logic                  swap_request,
  output logic                  swap_done,
  output logic                  active_buffer,
  input  logic                  lcd_tick,
  input  logic                  lcd_next_frame,
  input  logic                  lcd_data_enable,
`ifdef FB_TEST_PATTERN_EN
  input  logic                  test_pattern,
`endif
  output logic [7:0]            lcd_red,
  output logic [7:0]            lcd_green,
  output logic [7:0]            lcd_blue,
  output logic [15:0]           underflow_count
);

  localparam int WORDS = H_ACTIVE * V_ACTIVE / 2;
  localparam int REM_W = $clog2(WORDS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RECV} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;         // next word to request
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d; // address of burst on the bus
  logic [REM_W-1:0]      rem_q, rem_d;
  logic [7:0]            bc_q, bc_d, beats_q, beats_d, burst_sz;
  logic                  disc_q, disc_d;         // current burst belongs to a dead frame
  logic                  pend_q, pend_d, act_q, act_d, swap_done_q, swap_done_d;
  logic                  do_swap;
  logic [31:0]           base_sel;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  half_q, half_d;
  logic [7:0]            red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [15:0]           uf_q, uf_d;
  logic                  push, pop, pix_en, can_launch;
  logic [47:0]           rd_word;
  logic [23:0]           pix;

  // Only RGB is stored; the pad byte of each pixel is dropped on entry.
  logic [47:0] mem [FIFO_DEPTH];
  logic        unused_pad;
  assign unused_pad = ^{avm_readdata[63:56], avm_readdata[31:24]};

  assign burst_sz   = (32'(rem_q) >= 32'(BURST_LEN)) ? 8'(BURST_LEN) : 8'(rem_q);
  // Only one burst is ever in flight and launches happen from IDLE, so the
  // FIFO occupancy alone is the full commitment.
  assign can_launch = (rem_q != '0) &&
                      ((32'(FIFO_DEPTH) - 32'(cnt_q)) >= 32'(BURST_LEN));
  assign push = (state_q == S_RECV) && avm_readdatavalid && !disc_q && !lcd_next_frame;
  assign pix_en  = lcd_tick && lcd_data_enable;
  assign pop     = pix_en && (cnt_q != '0) && half_q && !lcd_next_frame;
  assign rd_word = mem[rd_ptr_q];
  assign pix     = half_q ? rd_word[47:24] : rd_word[23:0];

`ifdef FB_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam int X_W   = $clog2(H_ACTIVE + 1);
  logic [X_W-1:0] x_q, x_d;
  logic [2:0]     bar;
  int             bar_i;

  always_comb begin
    x_d = x_q;
    if (lcd_tick) x_d = lcd_data_enable ? x_q + X_W'(1) : '0;  // blank clears per line
    bar_i = 32'(x_q) / BAR_W;
    bar   = (bar_i > 7) ? 3'd7 : 3'(bar_i);
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) x_q <= '0;
    else          x_q <= x_d;
`endif

  // Next-state logic of the read FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (!lcd_next_frame && can_launch) state_d = S_REQ;
      S_REQ:  if (!avm_waitrequest) state_d = S_RECV;
      S_RECV: if (avm_readdatavalid && beats_q == 8'd1) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read datapath and page-flip bookkeeping.
  always_comb begin
    addr_d      = addr_q;
    rem_d       = rem_q;
    req_addr_d  = req_addr_q;
    bc_d        = bc_q;
    beats_d     = beats_q;
    disc_d      = disc_q;
    pend_d      = pend_q | swap_request;
    act_d       = act_q;
    swap_done_d = 1'b0;
    do_swap     = pend_q | swap_request;
    base_sel    = base_address0;
    if (lcd_next_frame) begin
      act_d       = act_q ^ do_swap;
      swap_done_d = do_swap;
      pend_d      = 1'b0;
      base_sel    = act_d ? base_address1 : base_address0;
      addr_d      = ADDR_WIDTH'(base_sel >> 3);
      rem_d       = REM_W'(WORDS);
    end
    case (state_q)
      S_IDLE: if (!lcd_next_frame && can_launch) begin
        bc_d       = burst_sz;
        req_addr_d = addr_q;
      end
      S_REQ: begin
        // A burst caught by a frame start still completes its handshake
        // and its beats are drained, just never pushed.
        if (lcd_next_frame) disc_d = 1'b1;
        if (!avm_waitrequest) begin
          beats_d = bc_q;
          if (!lcd_next_frame && !disc_q) begin
            addr_d = addr_q + ADDR_WIDTH'(bc_q);
            rem_d  = rem_q - REM_W'(bc_q);
          end
        end
      end
      S_RECV: begin
        if (lcd_next_frame) disc_d = 1'b1;
        if (avm_readdatavalid) begin
          beats_d = beats_q - 8'd1;
          if (beats_q == 8'd1) disc_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // FIFO pointers and pixel output.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    half_d   = half_q;
    red_d    = red_q;
    green_d  = green_q;
    blue_d   = blue_q;
    uf_d     = uf_q;
    if (pix_en) begin
      // Half-select toggles even when starved to keep pixel phase aligned.
      half_d = ~half_q;
      if (cnt_q != '0) begin
        red_d   = pix[7:0];
        green_d = pix[15:8];
        blue_d  = pix[23:16];
      end else begin
        red_d   = 8'h00;
        green_d = 8'h00;
        blue_d  = 8'h00;
      end
`ifdef FB_TEST_PATTERN_EN
      if (test_pattern) begin
        red_d   = {8{~bar[1]}};
        green_d = {8{~bar[2]}};
        blue_d  = {8{~bar[0]}};
      end else if (cnt_q == '0 && uf_q != 16'hFFFF) begin
        uf_d = uf_q + 16'd1;
      end
`else
      if (cnt_q == '0 && uf_q != 16'hFFFF) uf_d = uf_q + 16'd1;
`endif
    end
    if (lcd_next_frame) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      half_d   = 1'b0;
    end
  end

  always_ff @(posedge clock)
    if (push) mem[wr_ptr_q] <= {avm_readdata[55:32], avm_readdata[23:0]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      req_addr_q  <= '0;
      bc_q        <= '0;
      beats_q     <= '0;
      disc_q      <= 1'b0;
      pend_q      <= 1'b0;
      act_q       <= 1'b0;
      swap_done_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      half_q      <= 1'b0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      uf_q        <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      req_addr_q  <= req_addr_d;
      bc_q        <= bc_d;
      beats_q     <= beats_d;
      disc_q      <= disc_d;
      pend_q      <= pend_d;
      act_q       <= act_d;
      swap_done_q <= swap_done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      uf_q        <= uf_d;
    end
  end

  // Output logic.
  always_comb begin
    avm_read        = (state_q == S_REQ);
    avm_address     = req_addr_q;
    avm_burstcount  = bc_q;
    swap_done       = swap_done_q;
    active_buffer   = act_q;
    lcd_red         = red_q;
    lcd_green       = green_q;
    lcd_blue        = blue_q;
    underflow_count = uf_q;
  end

endmodule

// File: tb/tb_fb_scanout.sv
module tb_fb_scanout;
  localparam int H = 10, V = 2, BL = 4, FD = 8, AW = 29;
  localparam logic [31:0]   BASE0 = 32'h3800_0000, BASE1 = 32'h3810_0000;
  localparam logic [AW-1:0] B0W = 29'h0700_0000, B1W = 29'h0702_0000;

  logic clock = 0, reset_n = 0;
  logic [AW-1:0] avm_address;
  logic [7:0] avm_burstcount;
  logic avm_read, avm_waitrequest = 0, avm_readdatavalid = 0;
  logic [63:0] avm_readdata = '0;
  logic [31:0] base_address0 = BASE0, base_address1 = BASE1;
  logic swap_request = 0, swap_done, active_buffer;
  logic lcd_tick = 0, lcd_next_frame = 0, lcd_data_enable = 0;
  logic [7:0] lcd_red, lcd_green, lcd_blue;
  logic [15:0] underflow_count;

  fb_scanout #(.H_ACTIVE(H), .V_ACTIVE(V), .BURST_LEN(BL), .FIFO_DEPTH(FD), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset_n(reset_n),
    .avm_address(avm_address), .avm_burstcount(avm_burstcount), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .base_address0(base_address0), .base_address1(base_address1),
    .swap_request(swap_request), .swap_done(swap_done), .active_buffer(active_buffer),
    .lcd_tick(lcd_tick), .lcd_next_frame(lcd_next_frame), .lcd_data_enable(lcd_data_enable),
    .lcd_red(lcd_red), .lcd_green(lcd_green), .lcd_blue(lcd_blue),
    .underflow_count(underflow_count));

  always #5 clock = ~clock;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Avalon slave model: word w returns {2w+1, 2w}; logs every accepted burst.
  typedef struct { logic [AW-1:0] addr; int bc; } burst_t;
  burst_t blog[$];
  logic [63:0] beatq[$];
  int stall_cfg = 0, stall_cnt = 0, stray_req = 0, stray_done = 0;
  bit deliver_en = 1, in_stall = 0;
  logic [AW-1:0] st_addr;
  logic [7:0] st_bc;

  always @(negedge clock) begin
    if (!reset_n) begin
      beatq.delete();
      avm_readdatavalid = 0;
      avm_waitrequest = 0;
      stall_cnt = 0;
      in_stall = 0;
    end else begin
      avm_readdatavalid = 0;
      if (stray_req != stray_done) begin
        stray_done = stray_req;
        avm_readdatavalid = 1;
        avm_readdata = 64'hAAAA_AAAA_AAAA_AAAA;
      end else if (deliver_en && beatq.size() > 0) begin
        avm_readdatavalid = 1;
        avm_readdata = beatq.pop_front();
      end
      avm_waitrequest = 0;
      if (avm_read) begin
        if (stall_cnt < stall_cfg) begin
          avm_waitrequest = 1;
          stall_cnt++;
          if (!in_stall) begin
            in_stall = 1; st_addr = avm_address; st_bc = avm_burstcount;
          end else begin
            chk("stall_addr", 32'(avm_address), 32'(st_addr));
            chk("stall_bc", 32'(avm_burstcount), 32'(st_bc));
          end
        end else begin
          in_stall = 0;
          stall_cnt = 0;
          blog.push_back('{avm_address, int'(avm_burstcount)});
          for (int i = 0; i < int'(avm_burstcount); i++) begin
            logic [31:0] w;
            w = 32'(avm_address) + 32'(i);
            beatq.push_back({2 * w + 1, 2 * w});
          end
        end
      end
    end
  end

  function automatic logic [23:0] px(input logic [AW-1:0] bw, input int p);
    logic [31:0] v;
    v = 2 * 32'(bw) + 32'(p);
    return {v[23:16], v[15:8], v[7:0]};
  endfunction

  logic [23:0] sb[$];

  task automatic pplus();
    @(posedge clock); #1;
  endtask

  task automatic tick_px(input bit de, input logic [23:0] exp);
    logic [23:0] e;
    @(negedge clock); lcd_tick = 1; lcd_data_enable = de;
    if (de) sb.push_back(exp);
    @(negedge clock); lcd_tick = 0; lcd_data_enable = 0;
    if (de) begin
      e = sb.pop_front();
      chk("pixel", 32'({lcd_blue, lcd_green, lcd_red}), 32'(e));
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic pulse_swap();
    @(negedge clock); swap_request = 1;
    @(negedge clock); swap_request = 0;
  endtask

  task automatic nf(input bit sw);
    @(negedge clock); lcd_next_frame = 1; swap_request = sw;
    @(negedge clock); lcd_next_frame = 0; swap_request = 0;
  endtask

  task automatic run_frame(input logic [AW-1:0] bw, input bit zero, input bit mid_swap);
    for (int y = 0; y < V; y++) begin
      if (mid_swap && y == 1) begin pulse_swap(); pulse_swap(); end
      for (int x = 0; x < H; x++) tick_px(1'b1, zero ? 24'h0 : px(bw, y * H + x));
      repeat (3) tick_px(1'b0, 24'h0);
    end
  endtask

  typedef struct {
    int stall; bit nf_swap; bit mid_swap; bit exp_sd; bit exp_act; logic [AW-1:0] exp_base;
  } fvec_t;
  fvec_t fv[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int start;
    fv[0] = '{5, 1'b0, 1'b1, 1'b0, 1'b0, B0W};  // swap requested mid-frame
    fv[1] = '{0, 1'b0, 1'b0, 1'b1, 1'b1, B1W};  // flip takes effect here
    fv[2] = '{0, 1'b1, 1'b0, 1'b1, 1'b0, B0W};  // request coincident with frame start
    fv[3] = '{2, 1'b0, 1'b0, 1'b0, 1'b0, B0W};

    repeat (3) @(negedge clock);
    chk("rst_read", 32'(avm_read), 0);
    chk("rst_bc", 32'(avm_burstcount), 0);
    chk("rst_addr", 32'(avm_address), 0);
    chk("rst_swap_done", 32'(swap_done), 0);
    chk("rst_active", 32'(active_buffer), 0);
    chk("rst_rgb", 32'({lcd_blue, lcd_green, lcd_red}), 0);
    chk("rst_underflow", 32'(underflow_count), 0);
    pplus(); reset_n = 1;
    pplus(); stray_req = 1;            // beat while IDLE must be ignored
    repeat (5) @(negedge clock);
    chk("idle_no_read", 32'(avm_read), 0);

    for (int i = 0; i < 4; i++) begin
      pplus(); stall_cfg = fv[i].stall; start = blog.size();
      nf(fv[i].nf_swap);
      chk("swap_done", 32'(swap_done), 32'(fv[i].exp_sd));
      chk("active_buffer", 32'(active_buffer), 32'(fv[i].exp_act));
      @(negedge clock);
      chk("swap_done_one_cycle", 32'(swap_done), 0);
      repeat (30) @(negedge clock);
      run_frame(fv[i].exp_base, 1'b0, fv[i].mid_swap);
      chk("active_hold", 32'(active_buffer), 32'(fv[i].exp_act));
      chk("underflow_zero", 32'(underflow_count), 0);
      chk("burst_count", 32'(blog.size() - start), 3);
      if (blog.size() >= start + 3)
        for (int k = 0; k < 3; k++) begin
          chk("burst_addr", 32'(blog[start + k].addr), 32'(fv[i].exp_base) + 32'(4 * k));
          chk("burst_len", 32'(blog[start + k].bc), (k < 2) ? 4 : 2);
        end
    end
    pplus(); stall_cfg = 0;

    // Frame start during RECV with three beats outstanding.
    pplus(); deliver_en = 0; start = blog.size();
    nf(1'b0);
    for (int t = 0; t < 50 && blog.size() == start; t++) pplus();
    chk("discard_burst_issued", 32'(blog.size() > start), 1);
    deliver_en = 1;
    pplus(); deliver_en = 0;
    nf(1'b0);
    pplus(); deliver_en = 1;
    for (int t = 0; t < 50 && blog.size() < start + 2; t++) pplus();
    chk("restart_issued", 32'(blog.size() >= start + 2), 1);
    if (blog.size() >= start + 2) begin
      chk("restart_addr", 32'(blog[start + 1].addr), 32'(B0W));
      chk("restart_len", 32'(blog[start + 1].bc), 4);
    end
    repeat (30) @(negedge clock);
    run_frame(B0W, 1'b0, 1'b0);
    chk("restart_bursts", 32'(blog.size() - start), 4);

    // Slave stalled for a whole frame; flip at the same time so reset has work.
    pplus(); stall_cfg = 1_000_000;
    nf(1'b1);
    chk("uf_active", 32'(active_buffer), 1);
    repeat (30) @(negedge clock);
    run_frame(B1W, 1'b1, 1'b0);
    chk("underflow_frame", 32'(underflow_count), H * V);
    @(negedge clock); lcd_tick = 1; lcd_data_enable = 1;
    repeat (65600) @(negedge clock);
    lcd_tick = 0; lcd_data_enable = 0;
    @(negedge clock);
    chk("underflow_sat", 32'(underflow_count), 32'h0000_FFFF);
    chk("req_stalled", 32'(avm_read), 1);

    pplus(); reset_n = 0; #1;
    chk("async_rst_read", 32'(avm_read), 0);
    chk("async_rst_bc", 32'(avm_burstcount), 0);
    chk("async_rst_addr", 32'(avm_address), 0);
    chk("async_rst_uf", 32'(underflow_count), 0);
    chk("async_rst_active", 32'(active_buffer), 0);
    pplus(); stall_cfg = 0; reset_n = 1;
    repeat (5) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
